// File: rtl/power_monitor_seq_if.sv
// Signal bundle between the power monitor sequencer and its start control,
// supply comparator mux and power switch.
interface power_monitor_seq_if #(
    parameter int NUM_CH = 7,
    parameter int SEL_W  = 3
);
    logic              start;
    logic              data;
    logic [NUM_CH-1:0] enable_mask;
    logic              kill_sw;
    logic [SEL_W-1:0]  sel;
    logic              fault;
    logic [SEL_W-1:0]  fault_ch;
    logic              sample_valid;
    logic              sample_bad;
    logic              scan_done;

    modport master (
        output start, data, enable_mask,
        input  kill_sw, sel, fault, fault_ch, sample_valid, sample_bad, scan_done
    );

    modport slave (
        input  start, data, enable_mask,
        output kill_sw, sel, fault, fault_ch, sample_valid, sample_bad, scan_done
    );
endinterface

// File: rtl/power_monitor_seq.sv
// Multi-channel supply monitor: scans comparator channels through an external
// mux, arms the power switch after one clean scan, trips on persistent faults.
module power_monitor_seq #(
    parameter int              NUM_CH         = 7,
    parameter int              SEL_W          = 3,
    parameter int              DWELL_CYCLES   = 1024,
    parameter logic [NUM_CH-1:0] EXPECT_MASK  = 7'b1010101,
    parameter int              FAULT_LIMIT    = 2,
    parameter int              HOLDOFF_CYCLES = 50000
) (
    input logic                clk,
    input logic                reset,
    power_monitor_seq_if.slave bus
);
    localparam int SEL_N = 1 << SEL_W;
    localparam int DW_W  = $clog2(DWELL_CYCLES);
    localparam int CNT_W = $clog2(FAULT_LIMIT + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [HO_W-1:0]  HOLD_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(FAULT_LIMIT);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_N-1:0] EXP_EXT    = SEL_N'(EXPECT_MASK);

    typedef enum logic [1:0] {IDLE, ARMING, RUN, TRIPPED} state_t;

    state_t           state, state_n;
    logic [DW_W-1:0]  dwell, dwell_n;
    logic [HO_W-1:0]  hold, hold_n;
    logic [CNT_W-1:0] bad_cnt   [SEL_N];
    logic [CNT_W-1:0] bad_cnt_n [SEL_N];
    logic [CNT_W-1:0] cnt_new;
    logic [SEL_W-1:0] sel_q, sel_n, fault_ch_q, fault_ch_n;
    logic             kill_q, kill_n, fault_q, fault_n;
    logic             sv_q, sv_n, sb_q, sb_n, sd_q, sd_n;
    logic             trip, clear_cnt;

    logic [SEL_N-1:0] en_ext;
    logic             sample, last_ch, bad;

    // Index-width-matched views so any legal NUM_CH/SEL_W pairing selects cleanly.
    assign en_ext  = SEL_N'(bus.enable_mask);
    assign sample  = (dwell == DWELL_LAST);
    assign last_ch = (sel_q == SEL_LAST);
    assign bad     = en_ext[sel_q] & (bus.data != EXP_EXT[sel_q]);

    assign bus.kill_sw      = kill_q;
    assign bus.sel          = sel_q;
    assign bus.fault        = fault_q;
    assign bus.fault_ch     = fault_ch_q;
    assign bus.sample_valid = sv_q;
    assign bus.sample_bad   = sb_q;
    assign bus.scan_done    = sd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dwell      <= '0;
            hold       <= '0;
            sel_q      <= '0;
            kill_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
            sv_q       <= 1'b0;
            sb_q       <= 1'b0;
            sd_q       <= 1'b0;
            for (int unsigned i = 0; i < SEL_N; i++) bad_cnt[i] <= '0;
        end else begin
            state      <= state_n;
            dwell      <= dwell_n;
            hold       <= hold_n;
            sel_q      <= sel_n;
            kill_q     <= kill_n;
            fault_q    <= fault_n;
            fault_ch_q <= fault_ch_n;
            sv_q       <= sv_n;
            sb_q       <= sb_n;
            sd_q       <= sd_n;
            bad_cnt    <= bad_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        dwell_n    = dwell;
        hold_n     = hold;
        sel_n      = sel_q;
        kill_n     = kill_q;
        fault_n    = fault_q;
        fault_ch_n = fault_ch_q;
        sv_n       = 1'b0;
        sb_n       = 1'b0;
        sd_n       = 1'b0;
        bad_cnt_n  = bad_cnt;
        cnt_new    = bad_cnt[sel_q];
        trip       = 1'b0;
        clear_cnt  = 1'b0;

        case (state)
            IDLE: begin
                kill_n    = 1'b0;
                sel_n     = '0;
                dwell_n   = '0;
                clear_cnt = 1'b1;
                if (bus.start) begin
                    state_n    = ARMING;
                    fault_n    = 1'b0;
                    fault_ch_n = '0;
                end
            end
            ARMING, RUN: begin
                if (sample) begin
                    dwell_n = '0;
                    sel_n   = last_ch ? '0 : sel_q + 1'b1;
                    sv_n    = 1'b1;
                    sb_n    = bad;
                    sd_n    = last_ch;
                    if (state == ARMING) begin
                        trip = bad;
                    end else begin
                        if (!bad)
                            cnt_new = '0;
                        else if (cnt_new != CNT_LIMIT)
                            cnt_new = cnt_new + 1'b1;
                        bad_cnt_n[sel_q] = cnt_new;
                        trip = (cnt_new == CNT_LIMIT);
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end

                // Trip outranks start falling; start falling outranks arming completion.
                if (trip) begin
                    state_n    = TRIPPED;
                    kill_n     = 1'b0;
                    fault_n    = 1'b1;
                    fault_ch_n = sel_q;
                    hold_n     = '0;
                end else if (!bus.start) begin
                    state_n   = IDLE;
                    kill_n    = 1'b0;
                    sel_n     = '0;
                    dwell_n   = '0;
                    clear_cnt = 1'b1;
                end else if (state == ARMING && sample && last_ch) begin
                    state_n = RUN;
                    kill_n  = 1'b1;
                end
            end
            TRIPPED: begin
                kill_n = 1'b0;
                if (hold != HOLD_LAST) begin
                    hold_n = hold + 1'b1;
                end else if (!bus.start) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    dwell_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (clear_cnt)
            for (int unsigned i = 0; i < SEL_N; i++) bad_cnt_n[i] = '0;
    end
endmodule

// File: doc/power_monitor_seq.md
Name: power_monitor_seq

Overview:
Parametrised successor to the single-channel power kill sequencer. It scans NUM_CH multiplexed supply-monitor channels through an external analog mux (sel). After a settle dwell it samples one comparator line (data) per channel against a per-channel expected polarity. It energises the power switch (kill_sw high = power on) only after one clean arming scan, and trips with a latched fault and channel ID after FAULT_LIMIT consecutive bad samples on any enabled channel. It sits between the top-level start control and the board power switch/mux.

Parameters:
NUM_CH, 7, number of monitored channels (2..16)
SEL_W, 3, width of sel; must satisfy 2^SEL_W >= NUM_CH
DWELL_CYCLES, 1024, clk cycles spent on each channel before sampling (>=2)
EXPECT_MASK, 7'b1010101, bit i = expected data level on channel i (1 = high is healthy)
FAULT_LIMIT, 2, consecutive bad samples on one channel that trip in RUN (>=1)
HOLDOFF_CYCLES, 50000, minimum cycles in TRIPPED before restart is possible (>=1)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
start  input  1  level request to power on; deassert = orderly power off
data  input  1  comparator output for currently selected channel (pre-synchronised)
enable_mask  input  NUM_CH  bit i = 1: channel i is checked; 0: visited but ignored
kill_sw  output  1  power switch enable, 1 = power on
sel  output  SEL_W  mux select, current channel
fault  output  1  latched trip flag
fault_ch  output  SEL_W  channel that caused the latched trip
sample_valid  output  1  one-cycle pulse on each sample
sample_bad  output  1  valid with sample_valid: sample mismatched and channel enabled
scan_done  output  1  one-cycle pulse when the sample of channel NUM_CH-1 is taken

Behaviour:
- Clock/reset: single clk; reset synchronous, active-high, overrides everything. All outputs are registered.
- Reset values: kill_sw=0, sel=0, fault=0, fault_ch=0, sample_valid=0, sample_bad=0, scan_done=0, state=IDLE, dwell counter=0, all per-channel bad counters=0.
- States:
  - IDLE: kill_sw=0, sel=0, dwell=0. start=1 at an edge -> ARMING; fault and fault_ch cleared on that edge.
  - ARMING: scan runs; kill_sw stays 0. Any bad sample -> TRIPPED immediately; FAULT_LIMIT is ignored here. Sample of channel NUM_CH-1 with no bad sample in the scan -> RUN; kill_sw=1 from the same edge.
  - RUN: kill_sw=1, scan repeats continuously. A bad sample increments that channel's bad counter; a good sample, or a disabled channel, clears it. Counter reaching FAULT_LIMIT -> TRIPPED.
  - TRIPPED: kill_sw=0, fault=1, fault_ch=sel of the offending sample. Holdoff counter runs HOLDOFF_CYCLES. After expiry -> IDLE only when start=0; start must be re-asserted to restart.
- Scan timing:
  - Dwell counter counts 0..DWELL_CYCLES-1 on each channel.
  - The sample is taken on the edge where the counter equals DWELL_CYCLES-1. On that same edge: sample_valid=1, sel advances (NUM_CH-1 wraps to 0) and the counter returns to 0.
  - Channel period is exactly DWELL_CYCLES; scan period is NUM_CH*DWELL_CYCLES, independent of enable_mask.
- Check: bad = enable_mask[sel] & (data != EXPECT_MASK[sel]). data is sampled only on the sample edge.
- start deasserted in ARMING or RUN -> IDLE next edge: kill_sw=0, no fault, bad counters cleared.
- Simultaneous events:
  - Trip and start falling on the same edge: trip wins (TRIPPED, fault=1).
  - Arming completion and start falling on the same edge: IDLE, kill_sw stays 0.
- enable_mask changes take effect at the next sample; they are not latched.
- Bad counters saturate at FAULT_LIMIT and are cleared on entry to ARMING.
- reset mid-RUN: kill_sw=0 on the reset edge. Latched fault is lost.

Test Plan:
(Params for all scenarios: NUM_CH=3, DWELL_CYCLES=4, FAULT_LIMIT=2, HOLDOFF_CYCLES=8, EXPECT_MASK=3'b101, enable_mask=3'b111.)
- Clean power-up: start=1 at edge 0, data always healthy -> samples at edges 4, 8, 12 with sel 0, 1, 2; scan_done at 12; kill_sw=1 from edge 12.
- Arming fault: data=0 while sel=1 ... wait, sel=1 expects low; so data=1 while sel=1 -> sample_bad at edge 8; TRIPPED, fault=1, fault_ch=1, kill_sw never 1.
- RUN debounce: in RUN, one bad sample on ch2 then good -> no trip. Two consecutive bad samples on ch2 (one scan apart) -> trip at the second, fault_ch=2, kill_sw=0 next edge.
- Disabled channel: enable_mask=3'b110 with ch0 data wrong -> sample_bad=0, RUN reached, sample cadence unchanged.
- Orderly off plus holdoff: start=0 in RUN -> IDLE, kill_sw=0, fault=0. After a trip, holding start=1 keeps TRIPPED past 8 cycles; start=0 -> IDLE; start=1 -> fault cleared, ARMING.
- Reset mid-RUN with kill_sw=1 -> all outputs at reset values on the next edge.
